transmissor_pedidos: RTL
========================

# transmissor_pedidos

Request transmitter feeding the elevator datapath: buffers passenger requests (origin floor, destination floor) from the call-panel front-end and replays them one at a time onto the datapath's `origem`/`destino`/`novaEntrada` inputs. The datapath detects requests on the rising edge of `novaEntrada`, so this block guarantees a clean high/low framing per request with stable operands. It sits between the debounced call panel and the datapath, alongside the control unit that drives `ocupado`.

## Interface
- `ANDARES`, 8: number of valid floors, 2..16. Floors are 0..ANDARES-1.
- `PROFUNDIDADE`, 4: FIFO depth in entries, power of two, 2..16.
- `T_ALTO`, 4: cycles `novaEntrada` is held high per request, ≥1.
- `T_BAIXO`, 2: cycles `novaEntrada` is held low after each request, ≥1.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `registra` in 1: single-cycle strobe; sample `origem_in`/`destino_in` this cycle.
- `origem_in` in 4: requested origin floor.
- `destino_in` in 4: requested destination floor.
- `ocupado` in 1: control unit busy; no new transfer starts while high.
- `origem` out 4: origin presented to the datapath (registered).
- `destino` out 4: destination presented to the datapath (registered).
- `novaEntrada` out 1: request frame strobe (registered).
- `vazia` out 1: FIFO empty.
- `cheia` out 1: FIFO full.
- `pendentes` out log2(PROFUNDIDADE)+1: entries currently queued.
- `descartado` out 1: one-cycle pulse when a strobed request is rejected.

## Operation
- Reset values: `origem`=0, `destino`=0, `novaEntrada`=0, `pendentes`=0, `vazia`=1, `cheia`=0, `descartado`=0. FSM returns to OCIOSO. FIFO pointers are cleared.
- Validation on `registra`: reject if `origem_in`==`destino_in`, `origem_in`≥ANDARES, or `destino_in`≥ANDARES. Rejected requests are not queued and pulse `descartado` on the next cycle.
- Push: a valid strobe is queued if the FIFO is not full, or if a pop occurs the same edge. Otherwise it is dropped and `descartado` pulses.
- FSM states:
  - OCIOSO: `novaEntrada`=0. If FIFO is non-empty and `ocupado`=0 at the edge, pop the head into `origem`/`destino` and go to ALTO.
  - ALTO: `novaEntrada`=1 for exactly T_ALTO cycles, then go to BAIXO. `ocupado` is ignored; a transfer in progress always completes.
  - BAIXO: `novaEntrada`=0 for exactly T_BAIXO cycles, then go to OCIOSO.
- `origem`/`destino` stay constant from the pop until the next pop; they are never changed during ALTO or BAIXO.
- One internal duration counter serves both ALTO and BAIXO. It is reloaded on every state entry; width is ceil(log2(max(T_ALTO,T_BAIXO)))+1.
- Floor values are 4-bit unsigned. No arithmetic is done on floors, only comparisons.

## Timing
- Strobe in cycle 0 with FIFO empty and `ocupado`=0: `pendentes`=1 in cycle 1; `novaEntrada`=1 in cycles 2..1+T_ALTO; `pendentes`=0 from cycle 2.
- Back-to-back queued requests: the rising edges of `novaEntrada` are exactly T_ALTO+T_BAIXO+1 cycles apart.
- `ocupado` is sampled only in OCIOSO; the transfer starts on the first edge where it is low.
- Simultaneous push and pop while full: the push is accepted, `pendentes` is unchanged, `cheia` stays 1.
- Strobe while empty: no same-cycle bypass; a pop is always from registered FIFO state.
- Reset asserted mid-frame: `novaEntrada` drops immediately (async) and all queued requests are lost.

## Structure
- Package `pedido_pkg`:
  - FSM state enum {OCIOSO, ALTO, BAIXO}.
  - `LARGURA_ANDAR`=4.
  - Packed request struct {origem, destino}.
- Sub-module `fila_pedidos`: synchronous FIFO of request structs with push, pop, count, empty and full outputs, and the same async active-low reset.
- FSM, validation and duration counter live in the top level.

## Test plan
- Single request: reset, strobe (2,5) with defaults → `novaEntrada` high in cycles 2–5, `origem`=2, `destino`=5 held, `pendentes` 1→0, `vazia` back to 1.
- Burst: strobe (0,3), (4,1), (7,2) on consecutive cycles → three frames with rising edges 7 cycles apart, in FIFO order.
- Rejection: strobe (3,3), (9,1) with ANDARES=8, then a strobe while `cheia`=1 with `ocupado`=1 → three `descartado` pulses, `pendentes` unchanged.
- Busy gating: queue (1,6) with `ocupado`=1 for 10 cycles → `novaEntrada` stays 0; the frame starts on the edge after `ocupado` falls. Raising `ocupado` during ALTO does not shorten the frame.
- Full plus simultaneous pop: fill 4 entries with `ocupado`=1, release, and strobe (5,0) on the pop edge → accepted, `pendentes`=4, five frames total.
- Reset mid-ALTO: assert `reset` low in the 2nd high cycle → `novaEntrada`=0 immediately, `pendentes`=0, no frame after release.

Source files
------------

// File: rtl/pedido_pkg.sv
// Shared types for the request transmitter: floor width, FSM state encoding and the
// packed request record stored in the FIFO.
package pedido_pkg;

    localparam int unsigned LARGURA_ANDAR = 4;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ALTO   = 2'd1,
        BAIXO  = 2'd2
    } estado_e;

    typedef struct packed {
        logic [LARGURA_ANDAR-1:0] origem;
        logic [LARGURA_ANDAR-1:0] destino;
    } pedido_t;

endpackage

// File: rtl/transmissor_pedidos_if.sv
// Bus between the call panel / control unit and the request transmitter.
//   registra, origem_in, destino_in : request strobe and operands from the call panel
//   ocupado                          : control unit busy
//   origem, destino, novaEntrada     : request frame presented to the datapath
//   vazia, cheia, pendentes          : FIFO status
//   descartado                       : one-cycle pulse for a rejected request
// Modport master is the transmitter's view; slave is the surrounding logic's view.
interface transmissor_pedidos_if #(
    parameter int unsigned PROFUNDIDADE = 4
) ();

    localparam int unsigned LARGURA_PEND = $clog2(PROFUNDIDADE) + 1;

    logic                                 registra;
    logic [pedido_pkg::LARGURA_ANDAR-1:0] origem_in;
    logic [pedido_pkg::LARGURA_ANDAR-1:0] destino_in;
    logic                                 ocupado;
    logic [pedido_pkg::LARGURA_ANDAR-1:0] origem;
    logic [pedido_pkg::LARGURA_ANDAR-1:0] destino;
    logic                                 novaEntrada;
    logic                                 vazia;
    logic                                 cheia;
    logic [LARGURA_PEND-1:0]              pendentes;
    logic                                 descartado;

    modport master (
        input  registra, origem_in, destino_in, ocupado,
        output origem, destino, novaEntrada, vazia, cheia, pendentes, descartado
    );

    modport slave (
        output registra, origem_in, destino_in, ocupado,
        input  origem, destino, novaEntrada, vazia, cheia, pendentes, descartado
    );

endinterface

// File: rtl/fila_pedidos.sv
// Synchronous FIFO of request records.
//   clock, reset : rising-edge clock, asynchronous active-low reset (clears pointers/count)
//   push, dadoIn : write one record (ignored when full unless a pop happens the same edge)
//   pop, dadoOut : discard the head (ignored when empty); dadoOut is the current head
//   contagem     : number of stored records
//   vazia, cheia : empty / full flags
module fila_pedidos
    import pedido_pkg::*;
#(
    parameter int unsigned PROFUNDIDADE = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            push,
    input  pedido_t                         dadoIn,
    input  logic                            pop,
    output pedido_t                         dadoOut,
    output logic [$clog2(PROFUNDIDADE):0]   contagem,
    output logic                            vazia,
    output logic                            cheia
);

    localparam int unsigned LARGURA_PTR = $clog2(PROFUNDIDADE);
    localparam logic [LARGURA_PTR:0] CHEIO = PROFUNDIDADE[LARGURA_PTR:0];

    pedido_t                memoria [PROFUNDIDADE];
    logic [LARGURA_PTR-1:0] leituraQ;
    logic [LARGURA_PTR-1:0] escritaQ;
    logic [LARGURA_PTR:0]   contagemQ;
    logic                   popEf;
    logic                   pushEf;

    assign vazia    = (contagemQ == '0);
    assign cheia    = (contagemQ == CHEIO);
    assign contagem = contagemQ;
    assign dadoOut  = memoria[leituraQ];

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign popEf  = pop && !vazia;
    assign pushEf = push && (!cheia || popEf);

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            leituraQ  <= '0;
            escritaQ  <= '0;
            contagemQ <= '0;
        end else begin
            if (pushEf) escritaQ <= escritaQ + 1'b1;
            if (popEf)  leituraQ <= leituraQ + 1'b1;
            case ({pushEf, popEf})
                2'b10:   contagemQ <= contagemQ + 1'b1;
                2'b01:   contagemQ <= contagemQ - 1'b1;
                default: contagemQ <= contagemQ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (pushEf) memoria[escritaQ] <= dadoIn;
    end

endmodule

// File: rtl/transmissor_pedidos.sv
// Request transmitter: validates and queues (origem, destino) requests from the call panel
// and replays them to the datapath as frames of T_ALTO cycles with novaEntrada high
// followed by T_BAIXO cycles low, with operands held stable from pop to next pop.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   bus (master) : call-panel strobe/operands, ocupado from the control unit, datapath
//                  outputs origem/destino/novaEntrada and FIFO status
module transmissor_pedidos
    import pedido_pkg::*;
#(
    parameter int unsigned ANDARES      = 8,
    parameter int unsigned PROFUNDIDADE = 4,
    parameter int unsigned T_ALTO       = 4,
    parameter int unsigned T_BAIXO      = 2
) (
    input logic                   clock,
    input logic                   reset,
    transmissor_pedidos_if.master bus
);

    localparam int unsigned T_MAX        = (T_ALTO > T_BAIXO) ? T_ALTO : T_BAIXO;
    localparam int unsigned LARGURA_CONT = $clog2(T_MAX) + 1;
    localparam int unsigned LARGURA_PEND = $clog2(PROFUNDIDADE) + 1;
    localparam logic [LARGURA_CONT-1:0] CARGA_ALTO  = LARGURA_CONT'(T_ALTO - 1);
    localparam logic [LARGURA_CONT-1:0] CARGA_BAIXO = LARGURA_CONT'(T_BAIXO - 1);
    // One extra bit so ANDARES=16 is representable.
    localparam logic [LARGURA_ANDAR:0]  LIMITE      = ANDARES[LARGURA_ANDAR:0];

    estado_e                  estadoQ, estadoD;
    logic [LARGURA_CONT-1:0]  contQ, contD;
    logic [LARGURA_ANDAR-1:0] origemQ, destinoQ;
    logic                     novaEntradaQ;
    logic                     descartadoQ;

    pedido_t                  novo;
    pedido_t                  cabeca;
    logic                     valido;
    logic                     push;
    logic                     pop;
    logic                     vazia;
    logic                     cheia;
    logic [LARGURA_PEND-1:0]  contagem;

    assign novo.origem  = bus.origem_in;
    assign novo.destino = bus.destino_in;

    assign valido = bus.registra
                 && (bus.origem_in != bus.destino_in)
                 && ({1'b0, bus.origem_in} < LIMITE)
                 && ({1'b0, bus.destino_in} < LIMITE);

    // Pop only from registered FIFO state, so a strobe into an empty FIFO never bypasses.
    assign pop  = (estadoQ == OCIOSO) && !vazia && !bus.ocupado;
    assign push = valido && (!cheia || pop);

    fila_pedidos #(
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fila (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .dadoIn   (novo),
        .pop      (pop),
        .dadoOut  (cabeca),
        .contagem (contagem),
        .vazia    (vazia),
        .cheia    (cheia)
    );

    // The counter is reloaded on every state entry and counts down to zero.
    always_comb begin
        estadoD = estadoQ;
        contD   = contQ;
        case (estadoQ)
            OCIOSO: begin
                if (pop) begin
                    estadoD = ALTO;
                    contD   = CARGA_ALTO;
                end
            end
            ALTO: begin
                if (contQ == '0) begin
                    estadoD = BAIXO;
                    contD   = CARGA_BAIXO;
                end else begin
                    contD = contQ - 1'b1;
                end
            end
            BAIXO: begin
                if (contQ == '0) begin
                    estadoD = OCIOSO;
                    contD   = '0;
                end else begin
                    contD = contQ - 1'b1;
                end
            end
            default: begin
                estadoD = OCIOSO;
                contD   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estadoQ      <= OCIOSO;
            contQ        <= '0;
            origemQ      <= '0;
            destinoQ     <= '0;
            novaEntradaQ <= 1'b0;
            descartadoQ  <= 1'b0;
        end else begin
            estadoQ      <= estadoD;
            contQ        <= contD;
            novaEntradaQ <= (estadoD == ALTO);
            descartadoQ  <= bus.registra && !push;
            if (pop) begin
                origemQ  <= cabeca.origem;
                destinoQ <= cabeca.destino;
            end
        end
    end

    assign bus.origem      = origemQ;
    assign bus.destino     = destinoQ;
    assign bus.novaEntrada = novaEntradaQ;
    assign bus.vazia       = vazia;
    assign bus.cheia       = cheia;
    assign bus.pendentes   = contagem;
    assign bus.descartado  = descartadoQ;

endmodule
